// File: rtl/saturate_clamp.sv
// Clamps a wide value into a narrower signed or unsigned range, with an optional
// one-cycle output register and a sticky saturation-event counter.
module saturate_clamp #(
    parameter int unsigned IN_W    = 10,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned SIGNED  = 0,
    parameter int unsigned REG_OUT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             out_valid,
    output logic             sat_hi,
    output logic             sat_lo,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int unsigned PAD_U = IN_W - OUT_W;
    localparam int unsigned PAD_S = IN_W - OUT_W + 1;

    // Range limits expressed at the full input width so no bits are lost before comparing.
    localparam logic [IN_W-1:0] UMAX = {{PAD_U{1'b0}}, {OUT_W{1'b1}}};
    localparam logic [IN_W-1:0] SMAX = {{PAD_S{1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [IN_W-1:0] SMIN = {{PAD_S{1'b1}}, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0] dout_c;
    logic             sat_hi_c;
    logic             sat_lo_c;
    logic [CNT_W-1:0] sat_cnt_q;
    logic [CNT_W-1:0] sat_cnt_d;

    always_comb begin
        dout_c   = din[OUT_W-1:0];
        sat_hi_c = 1'b0;
        sat_lo_c = 1'b0;
        if (SIGNED != 0) begin
            if ($signed(din) > $signed(SMAX)) begin
                dout_c   = SMAX[OUT_W-1:0];
                sat_hi_c = 1'b1;
            end else if ($signed(din) < $signed(SMIN)) begin
                dout_c   = SMIN[OUT_W-1:0];
                sat_lo_c = 1'b1;
            end
        end else if (din > UMAX) begin
            dout_c   = UMAX[OUT_W-1:0];
            sat_hi_c = 1'b1;
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic [OUT_W-1:0] dout_q;
        logic             out_valid_q;
        logic             sat_hi_q;
        logic             sat_lo_q;

        // Free-running output stage; out_valid marks which samples matter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q      <= '0;
                out_valid_q <= 1'b0;
                sat_hi_q    <= 1'b0;
                sat_lo_q    <= 1'b0;
            end else begin
                dout_q      <= dout_c;
                out_valid_q <= in_valid;
                sat_hi_q    <= sat_hi_c;
                sat_lo_q    <= sat_lo_c;
            end
        end

        assign dout      = dout_q;
        assign out_valid = out_valid_q;
        assign sat_hi    = sat_hi_q;
        assign sat_lo    = sat_lo_q;
    end else begin : g_comb
        assign dout      = dout_c;
        assign out_valid = in_valid;
        assign sat_hi    = sat_hi_c;
        assign sat_lo    = sat_lo_c;
    end

    // Clear wins over increment; the count sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (cnt_clr) begin
            sat_cnt_d = '0;
        end else if (in_valid && (sat_hi_c || sat_lo_c) && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_saturate_clamp.sv
// Scoreboard bench for saturate_clamp: four configurations (unsigned comb,
// unsigned registered, signed comb, 2-bit counter) driven one after another.
module tb_saturate_clamp;

    logic clk;
    logic rst_n;

    logic [9:0]  din0, din1, din2, din3;
    logic        iv0, iv1, iv2, iv3;
    logic        clr0, clr1, clr2, clr3;
    logic [7:0]  dout0, dout1, dout2, dout3;
    logic        ov0, ov1, ov2, ov3;
    logic        hi0, hi1, hi2, hi3;
    logic        lo0, lo1, lo2, lo3;
    logic [15:0] cnt0, cnt1, cnt2;
    logic [1:0]  cnt3;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic [9:0] q3[$];

    int n_cmp = 0;
    int n_bad = 0;

    saturate_clamp #(.IN_W(10), .OUT_W(8), .SIGNED(0), .REG_OUT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .din(din0), .dout(dout0),
        .out_valid(ov0), .sat_hi(hi0), .sat_lo(lo0), .cnt_clr(clr0), .sat_cnt(cnt0));

    saturate_clamp #(.IN_W(10), .OUT_W(8), .SIGNED(0), .REG_OUT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .din(din1), .dout(dout1),
        .out_valid(ov1), .sat_hi(hi1), .sat_lo(lo1), .cnt_clr(clr1), .sat_cnt(cnt1));

    saturate_clamp #(.IN_W(10), .OUT_W(8), .SIGNED(1), .REG_OUT(0), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .din(din2), .dout(dout2),
        .out_valid(ov2), .sat_hi(hi2), .sat_lo(lo2), .cnt_clr(clr2), .sat_cnt(cnt2));

    saturate_clamp #(.IN_W(10), .OUT_W(8), .SIGNED(0), .REG_OUT(0), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .din(din3), .dout(dout3),
        .out_valid(ov3), .sat_hi(hi3), .sat_lo(lo3), .cnt_clr(clr3), .sat_cnt(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pops the oldest expectation for instance k and compares {dout,sat_hi,sat_lo}.
    task automatic mon(input int k, input logic [9:0] act);
        int         sz;
        logic [9:0] e;
        sz = 0;
        e  = '0;
        case (k)
            0: sz = q0.size();
            1: sz = q1.size();
            2: sz = q2.size();
            default: sz = q3.size();
        endcase
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d unexpected output: got %0d, expected none", k, act);
        end else begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            check($sformatf("dut%0d {dout,hi,lo}", k), int'(act), int'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov0) mon(0, {dout0, hi0, lo0});
            if (ov1) mon(1, {dout1, hi1, lo1});
            if (ov2) mon(2, {dout2, hi2, lo2});
            if (ov3) mon(3, {dout3, hi3, lo3});
        end
    end

    // Drives one sample just after a rising edge; valid samples queue their expectation.
    task automatic step(input int k, input logic [9:0] d, input logic v, input logic clr,
                        input logic [7:0] ed, input logic eh, input logic el);
        @(posedge clk);
        #1;
        case (k)
            0: begin din0 = d; iv0 = v; clr0 = clr; if (v) q0.push_back({ed, eh, el}); end
            1: begin din1 = d; iv1 = v; clr1 = clr; if (v) q1.push_back({ed, eh, el}); end
            2: begin din2 = d; iv2 = v; clr2 = clr; if (v) q2.push_back({ed, eh, el}); end
            default: begin din3 = d; iv3 = v; clr3 = clr; if (v) q3.push_back({ed, eh, el}); end
        endcase
    endtask

    task automatic idle(input int k);
        step(k, 10'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0; clr3 = 1'b0;

        #2;
        check("reset u1 dout", int'(dout1), 0);
        check("reset u1 out_valid", int'(ov1), 0);
        check("reset u1 sat_hi", int'(hi1), 0);
        check("reset u0 sat_cnt", int'(cnt0), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        check("u1 dout held after release", int'(dout1), 0);
        check("u1 out_valid held after release", int'(ov1), 0);

        // Unsigned, combinational: pass-through, boundary and clamping.
        step(0, 10'd0,    1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
        step(0, 10'd248,  1'b1, 1'b0, 8'd248, 1'b0, 1'b0);
        step(0, 10'd255,  1'b1, 1'b0, 8'd255, 1'b0, 1'b0);
        step(0, 10'd256,  1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
        step(0, 10'd1016, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
        step(0, 10'd1023, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
        step(0, 10'd512,  1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
        step(0, 10'd700,  1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
        step(0, 10'd900,  1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
        step(0, 10'd400,  1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
        step(0, 10'd1000, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
        idle(0);
        check("u0 sat_cnt after 5 valid + 3 invalid", int'(cnt0), 5);
        step(0, 10'd300,  1'b1, 1'b1, 8'd255, 1'b1, 1'b0);
        idle(0);
        check("u0 sat_cnt clear beats increment", int'(cnt0), 0);

        // Signed, combinational.
        step(2, 10'd824,  1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        step(2, 10'd127,  1'b1, 1'b0, 8'h7F, 1'b0, 1'b0);
        step(2, 10'd128,  1'b1, 1'b0, 8'h7F, 1'b1, 1'b0);
        step(2, 10'd896,  1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
        step(2, 10'd895,  1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        step(2, 10'd1023, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        idle(2);
        check("u2 sat_cnt signed", int'(cnt2), 3);

        // 2-bit counter saturates at 3.
        for (int i = 0; i < 6; i++) begin
            step(3, 10'(256 + i), 1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
        end
        idle(3);
        check("u3 sat_cnt sticks at all-ones", int'(cnt3), 3);

        // Registered unsigned: one-cycle latency.
        step(1, 10'd300, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
        step(1, 10'd17,  1'b1, 1'b0, 8'd17,  1'b0, 1'b0);
        idle(1);
        check("u1 sat_cnt", int'(cnt1), 1);
        step(1, 10'd600, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("u1 dout updates without in_valid", int'(dout1), 255);
        check("u1 out_valid low without in_valid", int'(ov1), 0);
        check("u1 sat_hi updates without in_valid", int'(hi1), 1);

        // Sample in flight when reset hits mid-cycle must vanish.
        din1 = 10'd500;
        iv1  = 1'b1;
        @(posedge clk);
        #1;
        check("u1 out_valid before reset", int'(ov1), 1);
        check("u1 sat_cnt before reset", int'(cnt1), 2);
        #1 rst_n = 1'b0;
        #1;
        check("u1 async reset dout", int'(dout1), 0);
        check("u1 async reset out_valid", int'(ov1), 0);
        check("u1 async reset sat_hi", int'(hi1), 0);
        check("u1 async reset sat_cnt", int'(cnt1), 0);
        iv1  = 1'b0;
        din1 = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("u0 queue drained", q0.size(), 0);
        check("u1 queue drained", q1.size(), 0);
        check("u2 queue drained", q2.size(), 0);
        check("u3 queue drained", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
